imuldiv_int_mul_iter_param: RTL and testbench

// Parametrised iterative shift-add integer multiplier; successor to the fixed 32-bit unit.

---
 rtl/imuldiv_int_mul_iter_param_pkg.sv | 24 ++
 rtl/imuldiv_int_mul_iter_param_if.sv | 37 +++
 rtl/imuldiv_int_mul_iter_param_dpath.sv | 85 ++++++++
 rtl/imuldiv_int_mul_iter_param.sv | 93 +++++++++
 tb/tb_imuldiv_int_mul_iter_param.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/imuldiv_int_mul_iter_param_pkg.sv
// Shared types and helpers for the iterative multiplier (and the divider that follows it).
package imuldiv_int_mul_iter_param_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states shared by the iterative mul/div units
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x != 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/imuldiv_int_mul_iter_param_if.sv
// val/rdy request/response bundle for the imuldiv multiplier.
interface imuldiv_int_mul_iter_param_if #(
    parameter int unsigned W = 32
);
    logic [W-1:0]   mulreq_msg_a;
    logic [W-1:0]   mulreq_msg_b;
    logic           mulreq_msg_signed;
    logic           mulreq_val;
    logic           mulreq_rdy;
    logic [2*W-1:0] mulresp_msg_result;
    logic           mulresp_val;
    logic           mulresp_rdy;

    // Requester side
    modport master (
        output mulreq_msg_a,
        output mulreq_msg_b,
        output mulreq_msg_signed,
        output mulreq_val,
        input  mulreq_rdy,
        input  mulresp_msg_result,
        input  mulresp_val,
        output mulresp_rdy
    );

    // Multiplier side
    modport slave (
        input  mulreq_msg_a,
        input  mulreq_msg_b,
        input  mulreq_msg_signed,
        input  mulreq_val,
        output mulreq_rdy,
        output mulresp_msg_result,
        output mulresp_val,
        input  mulresp_rdy
    );
endinterface

// File: rtl/imuldiv_int_mul_iter_param_dpath.sv
// Datapath of the iterative multiplier: operand magnitudes, shift-add accumulator,
// iteration counter and final sign correction.
module imuldiv_int_mul_iter_param_dpath
    import imuldiv_int_mul_iter_param_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic           signed_in,
    input  logic           load,
    input  logic           calc_en,
    input  logic           sign_en,
    output logic [2*W-1:0] result,
    output logic           counter_is_zero,
    output logic           b_rest_zero
);

    localparam int unsigned CNT_W = clog2(W);
    localparam int unsigned PW    = 2 * W;

    logic [PW-1:0]    a_reg;
    logic [W-1:0]     b_reg;
    logic [PW-1:0]    result_reg;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic             neg_in;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    negated;

    // Operand magnitudes; -2^(W-1) maps onto itself, read as unsigned 2^(W-1)
    always_comb begin
        a_mag  = (signed_in && a_in[W-1]) ? (~a_in + W'(1)) : a_in;
        b_mag  = (signed_in && b_in[W-1]) ? (~b_in + W'(1)) : b_in;
        neg_in = signed_in && (a_in[W-1] ^ b_in[W-1]);
    end

    // Full-width adder and two's complement negate; magnitudes cannot overflow 2W bits
    always_comb begin
        sum     = result_reg + a_reg;
        negated = ~result_reg + PW'(1);
    end

    // Status back to the controller
    always_comb begin
        counter_is_zero = (cnt == '0);
        b_rest_zero     = (b_reg[W-1:1] == '0);
    end

    // Operand, accumulator and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
        end else if (load) begin
            a_reg      <= PW'(a_mag);
            b_reg      <= b_mag;
            result_reg <= '0;
            cnt        <= CNT_W'(W - 1);
            neg        <= neg_in;
        end else if (calc_en) begin
            if (b_reg[0]) begin
                result_reg <= sum;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt - CNT_W'(1);
        end else if (sign_en) begin
            if (neg) begin
                result_reg <= negated;
            end
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/imuldiv_int_mul_iter_param.sv
// Parametrised iterative shift-add multiplier: control FSM plus datapath instance.
// Returns a 2W-bit product per request; optional early exit once b's remaining bits are zero.
module imuldiv_int_mul_iter_param
    import imuldiv_int_mul_iter_param_pkg::*;
#(
    parameter int unsigned W          = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    imuldiv_int_mul_iter_param_if.slave  mul
);

    mul_state_e state;
    mul_state_e state_next;

    logic       rdy_q;
    logic       val_q;

    logic       load;
    logic       calc_en;
    logic       sign_en;
    logic       counter_is_zero;
    logic       b_rest_zero;

    logic [2*W-1:0] result;

    // State register; handshake outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rdy_q <= 1'b0;
            val_q <= 1'b0;
        end else begin
            state <= state_next;
            rdy_q <= (state_next == ST_IDLE);
            val_q <= (state_next == ST_DONE);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        calc_en    = 1'b0;
        sign_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mul.mulreq_val && rdy_q) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                if (counter_is_zero || (EARLY_TERM && b_rest_zero)) begin
                    state_next = ST_SIGN;
                end
            end
            ST_SIGN: begin
                sign_en    = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (mul.mulresp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    imuldiv_int_mul_iter_param_dpath #(
        .W (W)
    ) u_dpath (
        .clk             (clk),
        .reset_n         (reset_n),
        .a_in            (mul.mulreq_msg_a),
        .b_in            (mul.mulreq_msg_b),
        .signed_in       (mul.mulreq_msg_signed),
        .load            (load),
        .calc_en         (calc_en),
        .sign_en         (sign_en),
        .result          (result),
        .counter_is_zero (counter_is_zero),
        .b_rest_zero     (b_rest_zero)
    );

    assign mul.mulreq_rdy         = rdy_q;
    assign mul.mulresp_val        = val_q;
    assign mul.mulresp_msg_result = result;

endmodule

// File: tb/tb_imuldiv_int_mul_iter_param.sv
// Self-checking bench: W=32 early-terminating unit and W=8 fixed-latency unit.
module tb_imuldiv_int_mul_iter_param;

    logic clk;
    logic reset_n;

    int n_assert = 0;
    int n_fail   = 0;

    imuldiv_int_mul_iter_param_if #(.W(32)) bus32 ();
    imuldiv_int_mul_iter_param_if #(.W(8))  bus8  ();

    imuldiv_int_mul_iter_param #(.W(32), .EARLY_TERM(1'b1)) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .mul     (bus32)
    );

    imuldiv_int_mul_iter_param #(.W(8), .EARLY_TERM(1'b0)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .mul     (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy32(input string tag);
        int n;
        n = 0;
        while (!bus32.mulreq_rdy && n < 50) begin
            step();
            n++;
        end
        chk({tag, " req_rdy"}, 64'(bus32.mulreq_rdy), 64'd1);
    endtask

    // Reference: full product from plain arithmetic; latency from highest set bit of |b|
    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input string tag);
        longint      sa, sb;
        logic [63:0] exp_p;
        logic [31:0] mag;
        int          exp_lat, lat;
        sa    = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb    = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        exp_p = 64'(sa * sb);
        mag   = (sgn && b[31]) ? 32'(-b) : b;
        exp_lat = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) exp_lat = i + 1;
        exp_lat += 2;

        wait_rdy32(tag);
        bus32.mulresp_rdy       = (hold == 0);
        bus32.mulreq_msg_a      = a;
        bus32.mulreq_msg_b      = b;
        bus32.mulreq_msg_signed = sgn;
        bus32.mulreq_val        = 1'b1;
        step();
        bus32.mulreq_val        = 1'b0;
        bus32.mulreq_msg_a      = $urandom();
        bus32.mulreq_msg_b      = $urandom();
        bus32.mulreq_msg_signed = 1'($urandom_range(0, 1));
        lat = 1;
        while (!bus32.mulresp_val && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, " resp_val"}, 64'(bus32.mulresp_val), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, bus32.mulresp_msg_result, exp_p);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " hold val"}, 64'(bus32.mulresp_val), 64'd1);
            chk({tag, " hold result"}, bus32.mulresp_msg_result, exp_p);
            chk({tag, " hold req_rdy"}, 64'(bus32.mulreq_rdy), 64'd0);
        end
        bus32.mulresp_rdy = 1'b1;
        step();
        chk({tag, " post val"}, 64'(bus32.mulresp_val), 64'd0);
        chk({tag, " post req_rdy"}, 64'(bus32.mulreq_rdy), 64'd1);
    endtask

    // Fixed-latency W=8 unit: always W+2 cycles to response
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       input string tag);
        int          sa, sb, lat, n;
        logic [15:0] exp_p;
        sa    = sgn ? int'($signed(a)) : int'({24'd0, a});
        sb    = sgn ? int'($signed(b)) : int'({24'd0, b});
        exp_p = 16'(sa * sb);
        n = 0;
        while (!bus8.mulreq_rdy && n < 50) begin
            step();
            n++;
        end
        chk({tag, " req_rdy"}, 64'(bus8.mulreq_rdy), 64'd1);
        bus8.mulresp_rdy       = 1'b1;
        bus8.mulreq_msg_a      = a;
        bus8.mulreq_msg_b      = b;
        bus8.mulreq_msg_signed = sgn;
        bus8.mulreq_val        = 1'b1;
        step();
        bus8.mulreq_val        = 1'b0;
        bus8.mulreq_msg_a      = 8'($urandom());
        bus8.mulreq_msg_b      = 8'($urandom());
        lat = 1;
        while (!bus8.mulresp_val && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, " resp_val"}, 64'(bus8.mulresp_val), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'd10);
        chk({tag, " result"}, 64'(bus8.mulresp_msg_result), 64'(exp_p));
        step();
        chk({tag, " post val"}, 64'(bus8.mulresp_val), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        reset_n = 1'b0;
        bus32.mulreq_msg_a = '0; bus32.mulreq_msg_b = '0; bus32.mulreq_msg_signed = 1'b0;
        bus32.mulreq_val = 1'b0; bus32.mulresp_rdy = 1'b1;
        bus8.mulreq_msg_a = '0;  bus8.mulreq_msg_b = '0;  bus8.mulreq_msg_signed = 1'b0;
        bus8.mulreq_val = 1'b0;  bus8.mulresp_rdy = 1'b1;

        // Reset state
        repeat (3) step();
        chk("reset req_rdy32", 64'(bus32.mulreq_rdy), 64'd0);
        chk("reset resp_val32", 64'(bus32.mulresp_val), 64'd0);
        chk("reset result32", bus32.mulresp_msg_result, 64'd0);
        chk("reset req_rdy8", 64'(bus8.mulreq_rdy), 64'd0);
        chk("reset resp_val8", 64'(bus8.mulresp_val), 64'd0);
        chk("reset result8", 64'(bus8.mulresp_msg_result), 64'd0);
        #2 reset_n = 1'b1;

        // Directed values, including extreme operands
        op32(32'd5, 32'd3, 1'b0, 0, "u5x3");
        op32(32'hFFFF_FFF9, 32'd6, 1'b1, 0, "s-7x6");
        op32(32'hFFFF_FFF9, 32'd0, 1'b1, 0, "s-7x0");
        op32(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "smin_sq");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "umax_sq");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "s-1_sq");
        op32(32'd1, 32'd1, 1'b0, 0, "u1x1");

        // Backpressure followed by a back-to-back request
        op32(32'd1234, 32'hFFFF_FF00, 1'b1, 10, "backpressure");
        op32(32'h0001_0000, 32'h0000_0101, 1'b0, 0, "back_to_back");

        // Reset while calculating: abort, no response
        wait_rdy32("rst_mid");
        bus32.mulreq_msg_a = 32'h1234_5678; bus32.mulreq_msg_b = 32'hFFFF_FFFF;
        bus32.mulreq_msg_signed = 1'b0; bus32.mulreq_val = 1'b1;
        step();
        bus32.mulreq_val = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid resp_val", 64'(bus32.mulresp_val), 64'd0);
        chk("rst_mid req_rdy", 64'(bus32.mulreq_rdy), 64'd0);
        chk("rst_mid result", bus32.mulresp_msg_result, 64'd0);
        step();
        reset_n = 1'b1;
        repeat (40) begin
            step();
            chk("rst_mid no_resp", 64'(bus32.mulresp_val), 64'd0);
        end
        op32(32'd12, 32'd12, 1'b0, 0, "after_reset");

        // Fixed-latency W=8 unit
        op8(8'h80, 8'h7F, 1'b1, "w8 -128x127");
        op8(8'h25, 8'h00, 1'b0, "w8 b0");
        op8(8'hFF, 8'hFF, 1'b0, "w8 umax_sq");
        for (int i = 0; i < 12; i++) begin
            op8(8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)), "w8 rand");
        end

        // Randomised W=32 operands with varied multiplier magnitude
        for (int i = 0; i < 40; i++) begin
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rb = 32'(-rb);
            op32(ra, rb, rs, (i % 8 == 3) ? 3 : 0, "w32 rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
